// File: rtl/stack_pkg.sv
// Shared types and helpers for the MCU stack sequencer.
package stack_pkg;

  localparam int unsigned AW_DEF = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_INT  = 3'd5,
    OP_RETI = 3'd6,
    OP_LDSP = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR1  = 3'd1,
    S_WR2  = 3'd2,
    S_RA   = 3'd3,
    S_RV   = 3'd4,
    S_LD   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SEL_REG   = 2'd0,
    SEL_PC    = 2'd1,
    SEL_FLAGS = 2'd2
  } scr_sel_e;

  typedef enum logic [1:0] {
    DST_REG   = 2'd0,
    DST_PC    = 2'd1,
    DST_FLAGS = 2'd2
  } pop_dst_e;

  typedef enum logic [1:0] {
    FLT_NONE = 2'd0,
    FLT_OVF  = 2'd1,
    FLT_UNF  = 2'd2
  } fault_e;

  // Destination of popped data: RETI restores FLAGS first, then PC.
  function automatic pop_dst_e pop_dst_of(input op_e op, input logic second_pass);
    pop_dst_e d;
    d = DST_REG;
    if (op == OP_RET) d = DST_PC;
    else if (op == OP_RETI) d = second_pass ? DST_PC : DST_FLAGS;
    return d;
  endfunction

endpackage

// File: rtl/stack_depth_ctr.sv
// Stack occupancy counter (0 .. 2**AW) with boundary flags.
module stack_depth_ctr
  import stack_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic clk,
  input  logic RST,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic full_o,
  output logic almost_full_o,
  output logic empty_o,
  output logic one_o
);

  localparam int unsigned DW = AW + 1;
  localparam logic [DW-1:0] CAP = DW'(1) << AW;

  logic [DW-1:0] depth_q;

  // Occupancy: +1 per RAM write, -1 per RAM read, cleared by SP load.
  always_ff @(posedge clk) begin
    if (RST || clr_i) begin
      depth_q <= '0;
    end else if (inc_i && !dec_i) begin
      depth_q <= depth_q + DW'(1);
    end else if (dec_i && !inc_i) begin
      depth_q <= depth_q - DW'(1);
    end
  end

  assign full_o        = (depth_q == CAP);
  assign almost_full_o = (depth_q >= (CAP - DW'(1)));
  assign empty_o       = (depth_q == '0);
  assign one_o         = (depth_q == DW'(1));

endmodule

// File: rtl/stack_seq.sv
// Stack sequencer: expands one stack command into RAM accesses and SP strobes.
module stack_seq
  import stack_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          op_valid,
  input  logic [2:0]    op_code,
  input  logic [AW-1:0] ld_data,
  output logic          op_ready,
  output logic          op_done,
  input  logic [AW-1:0] sp_cur,
  output logic          sp_ld,
  output logic          sp_incr,
  output logic          sp_decr,
  output logic [AW-1:0] sp_data_in,
  output logic [AW-1:0] scr_addr,
  output logic          scr_we,
  output logic [1:0]    scr_sel,
  output logic          pop_valid,
  output logic [1:0]    pop_dst,
  output logic          fault,
  output logic [1:0]    fault_code
);

  state_e        state_q;
  op_e           op_q;
  logic          pass_q;
  logic [AW-1:0] sp_data_q;
  logic          op_done_q, sp_ld_q, sp_incr_q, sp_decr_q, scr_we_q, pop_valid_q, fault_q;
  logic [AW-1:0] scr_addr_q;
  scr_sel_e      scr_sel_q;
  pop_dst_e      pop_dst_q;
  fault_e        fault_code_q;
  logic          full, almost_full, empty, one;

  stack_depth_ctr #(.AW(AW)) u_depth (
    .clk           (clk),
    .RST           (RST),
    .inc_i         (scr_we_q),
    .dec_i         (sp_incr_q),
    .clr_i         (sp_ld_q),
    .full_o        (full),
    .almost_full_o (almost_full),
    .empty_o       (empty),
    .one_o         (one)
  );

  // Sequencer FSM; outputs are registered one cycle ahead, so WR2/RA
  // addresses are computed from the SP value before the pending strobe lands.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      pass_q       <= 1'b0;
      sp_data_q    <= '0;
      op_done_q    <= 1'b0;
      sp_ld_q      <= 1'b0;
      sp_incr_q    <= 1'b0;
      sp_decr_q    <= 1'b0;
      scr_we_q     <= 1'b0;
      pop_valid_q  <= 1'b0;
      fault_q      <= 1'b0;
      scr_addr_q   <= '0;
      scr_sel_q    <= SEL_REG;
      pop_dst_q    <= DST_REG;
      fault_code_q <= FLT_NONE;
    end else begin
      op_done_q    <= 1'b0;
      sp_ld_q      <= 1'b0;
      sp_incr_q    <= 1'b0;
      sp_decr_q    <= 1'b0;
      scr_we_q     <= 1'b0;
      pop_valid_q  <= 1'b0;
      fault_q      <= 1'b0;
      scr_addr_q   <= '0;
      scr_sel_q    <= SEL_REG;
      pop_dst_q    <= DST_REG;
      fault_code_q <= FLT_NONE;
      unique case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            op_q   <= op_e'(op_code);
            pass_q <= 1'b0;
            unique case (op_e'(op_code))
              OP_PUSH, OP_CALL: begin
                if (full) begin
                  state_q <= S_LD; op_done_q <= 1'b1; fault_q <= 1'b1; fault_code_q <= FLT_OVF;
                end else begin
                  state_q    <= S_WR1;
                  scr_we_q   <= 1'b1;
                  sp_decr_q  <= 1'b1;
                  op_done_q  <= 1'b1;
                  scr_addr_q <= sp_cur - AW'(1);
                  scr_sel_q  <= (op_e'(op_code) == OP_CALL) ? SEL_PC : SEL_REG;
                end
              end
              OP_INT: begin
                if (almost_full) begin
                  state_q <= S_LD; op_done_q <= 1'b1; fault_q <= 1'b1; fault_code_q <= FLT_OVF;
                end else begin
                  state_q    <= S_WR1;
                  scr_we_q   <= 1'b1;
                  sp_decr_q  <= 1'b1;
                  scr_addr_q <= sp_cur - AW'(1);
                  scr_sel_q  <= SEL_PC;
                end
              end
              OP_POP, OP_RET, OP_RETI: begin
                if (empty || (op_e'(op_code) == OP_RETI && one)) begin
                  state_q <= S_LD; op_done_q <= 1'b1; fault_q <= 1'b1; fault_code_q <= FLT_UNF;
                end else begin
                  state_q    <= S_RA;
                  sp_incr_q  <= 1'b1;
                  scr_addr_q <= sp_cur;
                end
              end
              OP_LDSP: begin
                state_q   <= S_LD;
                sp_ld_q   <= 1'b1;
                sp_data_q <= ld_data;
                op_done_q <= 1'b1;
              end
              OP_NOP: begin
                state_q   <= S_LD;
                op_done_q <= 1'b1;
              end
            endcase
          end
        end
        S_WR1: begin
          if (op_q == OP_INT) begin
            state_q    <= S_WR2;
            scr_we_q   <= 1'b1;
            sp_decr_q  <= 1'b1;
            op_done_q  <= 1'b1;
            scr_addr_q <= sp_cur - AW'(2);
            scr_sel_q  <= SEL_FLAGS;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RA: begin
          state_q     <= S_RV;
          pop_valid_q <= 1'b1;
          pop_dst_q   <= pop_dst_of(op_q, pass_q);
          op_done_q   <= !(op_q == OP_RETI && !pass_q);
        end
        S_RV: begin
          if (op_q == OP_RETI && !pass_q) begin
            state_q    <= S_RA;
            pass_q     <= 1'b1;
            sp_incr_q  <= 1'b1;
            scr_addr_q <= sp_cur;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WR2, S_LD: state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  assign op_ready   = (state_q == S_IDLE) && !RST;
  assign op_done    = op_done_q;
  assign sp_ld      = sp_ld_q;
  assign sp_incr    = sp_incr_q;
  assign sp_decr    = sp_decr_q;
  assign sp_data_in = sp_data_q;
  assign scr_addr   = scr_addr_q;
  assign scr_we     = scr_we_q;
  assign scr_sel    = scr_sel_q;
  assign pop_valid  = pop_valid_q;
  assign pop_dst    = pop_dst_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq with a simple SP register model.
module tb_stack_seq;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, CALL = 3'd3,
                         RET = 3'd4, INT = 3'd5, RETI = 3'd6, LDSP = 3'd7;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       op_valid = 1'b0;
  logic [2:0] op_code = 3'd0;
  logic [7:0] ld_data = 8'h00;
  logic [7:0] sp = 8'h00;
  logic       op_ready, op_done, sp_ld, sp_incr, sp_decr, scr_we, pop_valid, fault;
  logic [7:0] sp_data_in, scr_addr;
  logic [1:0] scr_sel, pop_dst, fault_code;
  logic [21:0] e;
  int n_checks = 0;
  int n_fail = 0;

  stack_seq #(.AW(8)) dut (
    .clk(clk), .RST(RST), .op_valid(op_valid), .op_code(op_code), .ld_data(ld_data),
    .op_ready(op_ready), .op_done(op_done), .sp_cur(sp), .sp_ld(sp_ld), .sp_incr(sp_incr),
    .sp_decr(sp_decr), .sp_data_in(sp_data_in), .scr_addr(scr_addr), .scr_we(scr_we),
    .scr_sel(scr_sel), .pop_valid(pop_valid), .pop_dst(pop_dst), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // SP register model driven by the strobes.
  always @(posedge clk) begin
    if (sp_ld) sp <= sp_data_in;
    else if (sp_incr) sp <= sp + 8'd1;
    else if (sp_decr) sp <= sp - 8'd1;
  end

  // Output snapshot; fields without a qualifying strobe are zeroed.
  function automatic logic [21:0] obs();
    return {op_ready, op_done, fault, (fault ? fault_code : 2'b00), sp_ld, sp_incr, sp_decr,
            scr_we, (scr_we ? scr_sel : 2'b00), pop_valid, (pop_valid ? pop_dst : 2'b00),
            ((scr_we | sp_incr) ? scr_addr : 8'h00)};
  endfunction

  function automatic logic [21:0] mk(input int rdy, input int done, input int flt, input int code,
                                     input int ld, input int inc, input int dec, input int we,
                                     input int sel, input int pv, input int dst, input int addr);
    return {1'(rdy), 1'(done), 1'(flt), 2'(code), 1'(ld), 1'(inc), 1'(dec), 1'(we),
            2'(sel), 1'(pv), 2'(dst), 8'(addr)};
  endfunction

  // Present a command at a negedge, wait for accept, return at the negedge of T+1.
  task automatic issue(input logic [2:0] op, input logic [7:0] ld);
    int n;
    op_valid = 1'b1; op_code = op; ld_data = ld;
    n = 0;
    while (!op_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: op_ready got 0 required 1 within 20 cycles");
    end
    @(negedge clk);
    op_valid = 1'b0; op_code = NOP;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    e = mk(0,0,0,0,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reset_outs: got %h required %h", obs(), e); end
    n_checks++; if ({sp_data_in, scr_addr, scr_sel, pop_dst, fault_code} !== 22'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", {sp_data_in, scr_addr, scr_sel, pop_dst, fault_code}); end
    RST = 1'b0; #1;
    e = mk(1,0,0,0,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reset_release: got %h required %h", obs(), e); end
    @(negedge clk);
  endtask

  task automatic test_push_pop();
    issue(PUSH, 8'h00);
    e = mk(0,1,0,0,0,0,1,1,0,0,0,8'hFF); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL push_wr1: got %h required %h", obs(), e); end
    @(negedge clk);
    e = mk(1,0,0,0,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL push_idle: got %h required %h", obs(), e); end
    n_checks++; if (sp !== 8'hFF) begin n_fail++; $display("FAIL push_sp: got %h required ff", sp); end
    issue(POP, 8'h00);
    e = mk(0,0,0,0,0,1,0,0,0,0,0,8'hFF); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL pop_ra: got %h required %h", obs(), e); end
    @(negedge clk);
    e = mk(0,1,0,0,0,0,0,0,0,1,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL pop_rv: got %h required %h", obs(), e); end
    @(negedge clk);
    issue(POP, 8'h00);
    e = mk(0,1,1,2,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL pop_empty: got %h required %h", obs(), e); end
    @(negedge clk);
    issue(CALL, 8'h00);
    e = mk(0,1,0,0,0,0,1,1,1,0,0,8'hFF); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL call_wr1: got %h required %h", obs(), e); end
    @(negedge clk);
    issue(RET, 8'h00);
    e = mk(0,0,0,0,0,1,0,0,0,0,0,8'hFF); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL ret_ra: got %h required %h", obs(), e); end
    @(negedge clk);
    e = mk(0,1,0,0,0,0,0,0,0,1,1,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL ret_rv: got %h required %h", obs(), e); end
    @(negedge clk);
  endtask

  task automatic test_int_reti();
    issue(LDSP, 8'h80);
    e = mk(0,1,0,0,1,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL ldsp80: got %h required %h", obs(), e); end
    @(negedge clk);
    issue(INT, 8'h00);
    e = mk(0,0,0,0,0,0,1,1,1,0,0,8'h7F); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL int_wr1: got %h required %h", obs(), e); end
    @(negedge clk);
    e = mk(0,1,0,0,0,0,1,1,2,0,0,8'h7E); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL int_wr2: got %h required %h", obs(), e); end
    @(negedge clk);
    n_checks++; if (sp !== 8'h7E) begin n_fail++; $display("FAIL int_sp: got %h required 7e", sp); end
    issue(RETI, 8'h00);
    e = mk(0,0,0,0,0,1,0,0,0,0,0,8'h7E); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reti_ra1: got %h required %h", obs(), e); end
    @(negedge clk);
    e = mk(0,0,0,0,0,0,0,0,0,1,2,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reti_rv1: got %h required %h", obs(), e); end
    @(negedge clk);
    e = mk(0,0,0,0,0,1,0,0,0,0,0,8'h7F); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reti_ra2: got %h required %h", obs(), e); end
    @(negedge clk);
    e = mk(0,1,0,0,0,0,0,0,0,1,1,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reti_rv2: got %h required %h", obs(), e); end
    @(negedge clk);
    n_checks++; if (sp !== 8'h80) begin n_fail++; $display("FAIL reti_sp: got %h required 80", sp); end
    issue(RETI, 8'h00);
    e = mk(0,1,1,2,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reti_empty: got %h required %h", obs(), e); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    issue(LDSP, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin issue(PUSH, 8'h00); @(negedge clk); end
    n_checks++; if (sp !== 8'h00) begin n_fail++; $display("FAIL fill_sp: got %h required 00", sp); end
    issue(PUSH, 8'h00);
    e = mk(0,1,1,1,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL push_full: got %h required %h", obs(), e); end
    @(negedge clk);
    issue(INT, 8'h00);
    e = mk(0,1,1,1,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL int_full: got %h required %h", obs(), e); end
    @(negedge clk);
    n_checks++; if (sp !== 8'h00) begin n_fail++; $display("FAIL full_sp: got %h required 00", sp); end
    issue(POP, 8'h00); @(negedge clk); @(negedge clk);
    issue(INT, 8'h00);
    e = mk(0,1,1,1,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL int_255: got %h required %h", obs(), e); end
    @(negedge clk);
    issue(PUSH, 8'h00);
    e = mk(0,1,0,0,0,0,1,1,0,0,0,8'h00); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL push_255: got %h required %h", obs(), e); end
    @(negedge clk);
    issue(LDSP, 8'h10); @(negedge clk);
    issue(POP, 8'h00);
    e = mk(0,1,1,2,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL pop_after_ldsp: got %h required %h", obs(), e); end
    @(negedge clk);
    issue(PUSH, 8'h00); @(negedge clk);
    issue(RETI, 8'h00);
    e = mk(0,1,1,2,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reti_depth1: got %h required %h", obs(), e); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acc, dn;
    acc = 0; dn = 0;
    op_valid = 1'b1; op_code = LDSP; ld_data = 8'h40;
    for (int i = 0; i < 10; i++) begin
      if (op_ready) acc++;
      if (op_done) dn++;
      if (i == 1) begin
        e = mk(0,1,0,0,1,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL ldsp_ld: got %h required %h", obs(), e); end
        n_checks++; if (sp_data_in !== 8'h40) begin n_fail++; $display("FAIL ldsp_data: got %h required 40", sp_data_in); end
      end
      @(negedge clk);
    end
    op_valid = 1'b0; op_code = NOP;
    n_checks++; if (acc !== 5) begin n_fail++; $display("FAIL hold_accepts: got %0d required 5", acc); end
    n_checks++; if (dn !== 5) begin n_fail++; $display("FAIL hold_dones: got %0d required 5", dn); end
    @(negedge clk);
    n_checks++; if (sp !== 8'h40) begin n_fail++; $display("FAIL hold_sp: got %h required 40", sp); end
    issue(NOP, 8'h00);
    e = mk(0,1,0,0,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL nop_done: got %h required %h", obs(), e); end
    @(negedge clk);
  endtask

  task automatic test_rst_midop();
    issue(PUSH, 8'h00); @(negedge clk);
    issue(INT, 8'h00);
    @(negedge clk);
    e = mk(0,1,0,0,0,0,1,1,2,0,0,8'h3D); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL rst_wr2: got %h required %h", obs(), e); end
    RST = 1'b1;
    @(negedge clk);
    e = mk(0,0,0,0,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL rst_mid_outs: got %h required %h", obs(), e); end
    RST = 1'b0; #1;
    e = mk(1,0,0,0,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL rst_mid_ready: got %h required %h", obs(), e); end
    issue(POP, 8'h00);
    e = mk(0,1,1,2,0,0,0,0,0,0,0,0); n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL rst_pop_unf: got %h required %h", obs(), e); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_int_reti();
    test_overflow();
    test_back_to_back();
    test_rst_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
